sym_add_acc: RTL and testbench

SYM_ADD_ACC -- requirements
Module: sym_add_acc

---
 rtl/sym_add_pkg.sv | 21 ++
 rtl/sym_add_stage.sv | 53 +++++
 rtl/sym_add_acc.sv | 198 +++++++++++++++++++
 tb/tb_sym_add_acc.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sym_add_pkg.sv
// sym_add_pkg: shared FSM state encoding and width helper for sym_add_acc.
//   state_t : ACC (accumulating a frame) / DONE (frame sum ready for the output register)
//   clog2   : ceiling log2, used to derive the accumulator/output width
package sym_add_pkg;

   typedef enum logic {
      ACC  = 1'b0,
      DONE = 1'b1
   } state_t;

   // Ceiling log2; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sym_add_stage.sv
// sym_add_stage: mode-aware W -> W+1 extend-and-add with its pipeline register.
//   clk, rst_n : clock, async active-low reset
//   clear      : drop the registered pair (priority over load)
//   en         : pipeline advance; register holds when low
//   load       : a new pair is transferred this cycle
//   mode       : 1 = operands are two's complement, 0 = unsigned
//   a, b       : W-bit addends
//   s1_sum     : registered W+1-bit sum (lossless)
//   s1_mode    : mode the registered sum was formed in
//   s1_valid   : s1_sum holds a pair
module sym_add_stage
   import sym_add_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         en,
   input  logic         load,
   input  logic         mode,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W:0]   s1_sum,
   output logic         s1_mode,
   output logic         s1_valid
);

   logic [W:0] w_a_ext;
   logic [W:0] w_b_ext;

   // One extra bit is enough to hold the sum of two W-bit values in either mode.
   assign w_a_ext = mode ? {a[W-1], a} : {1'b0, a};
   assign w_b_ext = mode ? {b[W-1], b} : {1'b0, b};

   // Stage-1 register; holds while the pipeline is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_sum   <= '0;
         s1_mode  <= 1'b0;
         s1_valid <= 1'b0;
      end else if (clear) begin
         s1_valid <= 1'b0;
      end else if (en) begin
         s1_valid <= load;
         if (load) begin
            s1_sum  <= w_a_ext + w_b_ext;
            s1_mode <= mode;
         end
      end
   end

endmodule

// File: rtl/sym_add_acc.sv
// sym_add_acc: pipelined pairwise adder that sums ACC_LEN operand pairs per frame.
//   sys_clk, sys_rst_n  : clock, async active-low reset
//   clear               : synchronous frame abort (wins over a same-cycle input transfer)
//   signed_mode         : operand mode, latched on the first transfer of each frame
//   in_valid/in_ready   : input handshake for d1/d2
//   d1, d2              : W-bit addends
//   out_valid/out_ready : output handshake for sum_out
//   sum_out             : OW-bit frame sum
//   sum_signed          : mode sum_out was computed in
//   sat                 : sum_out was clamped
// Macro SYM_ADD_SAT_EN: when defined, the frame sum is clamped to the W-bit range
// of its mode and sat reports clamping; otherwise the sum is full precision, sat = 0.
module sym_add_acc
   import sym_add_pkg::*;
#(
   parameter  int unsigned W       = 8,
   parameter  int unsigned ACC_LEN = 4,
   localparam int unsigned OW      = W + 1 + clog2(ACC_LEN)
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic          clear,
   input  logic          signed_mode,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  d1,
   input  logic [W-1:0]  d2,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] sum_out,
   output logic          sum_signed,
   output logic          sat
);

   localparam int unsigned CW = clog2(ACC_LEN) + 1;

   logic          w_fire_in;
   logic          w_in_mode;
   logic [CW-1:0] r_in_cnt;
   logic          r_in_mode;

   logic [W:0]    w_s1_sum;
   logic          w_s1_mode;
   logic          w_s1_valid;
   logic [OW-1:0] w_s1_ext;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [CW-1:0] w_cnt_base;
   logic [OW-1:0] r_acc;
   logic [OW-1:0] w_acc_nxt;
   logic [OW-1:0] w_acc_base;
   logic          r_acc_mode;
   logic          w_acc_mode_nxt;
   logic          w_load;

   logic [OW-1:0] w_out_sum;
   logic          w_out_sat;

   // Whole pipeline advances unless a held result is waiting on the consumer.
   assign in_ready  = !(out_valid && !out_ready);
   assign w_fire_in = in_valid && in_ready;

   // First pair of a frame takes the live mode; later pairs use the latched one.
   assign w_in_mode = (r_in_cnt == '0) ? signed_mode : r_in_mode;

   // Input-side frame position, used only to latch the frame mode.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_in_cnt  <= '0;
         r_in_mode <= 1'b0;
      end else if (clear) begin
         r_in_cnt  <= '0;
      end else if (w_fire_in) begin
         if (r_in_cnt == '0) r_in_mode <= signed_mode;
         r_in_cnt <= (r_in_cnt == CW'(ACC_LEN - 1)) ? '0 : r_in_cnt + CW'(1);
      end
   end

   sym_add_stage #(
      .W (W)
   ) u_stage (
      .clk      (sys_clk),
      .rst_n    (sys_rst_n),
      .clear    (clear),
      .en       (in_ready),
      .load     (w_fire_in),
      .mode     (w_in_mode),
      .a        (d1),
      .b        (d2),
      .s1_sum   (w_s1_sum),
      .s1_mode  (w_s1_mode),
      .s1_valid (w_s1_valid)
   );

   assign w_s1_ext = w_s1_mode ? OW'($signed(w_s1_sum)) : OW'(w_s1_sum);

   // Stage 2 next state: DONE hands the finished sum to the output register and
   // restarts from zero, so the next frame's first pair is absorbed in the same cycle.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_acc_nxt      = r_acc;
      w_acc_mode_nxt = r_acc_mode;
      w_cnt_base     = r_cnt;
      w_acc_base     = r_acc;
      w_load         = 1'b0;
      if (clear) begin
         w_state_nxt    = ACC;
         w_cnt_nxt      = '0;
         w_acc_nxt      = '0;
         w_acc_mode_nxt = 1'b0;
      end else if (in_ready) begin
         if (r_state == DONE) begin
            w_load      = 1'b1;
            w_cnt_base  = '0;
            w_acc_base  = '0;
            w_state_nxt = ACC;
         end
         w_cnt_nxt = w_cnt_base;
         w_acc_nxt = w_acc_base;
         if (w_s1_valid) begin
            if (w_cnt_base == '0) w_acc_mode_nxt = w_s1_mode;
            w_acc_nxt = w_acc_base + w_s1_ext;
            if (w_cnt_base == CW'(ACC_LEN - 1)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = DONE;
            end else begin
               w_cnt_nxt = w_cnt_base + CW'(1);
            end
         end
      end
   end

   // FSM, count and accumulator registers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state    <= ACC;
         r_cnt      <= '0;
         r_acc      <= '0;
         r_acc_mode <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_acc      <= w_acc_nxt;
         r_acc_mode <= w_acc_mode_nxt;
      end
   end

`ifdef SYM_ADD_SAT_EN
   localparam logic [OW-1:0] SMAX = {{(OW - W + 1){1'b0}}, {(W - 1){1'b1}}};
   localparam logic [OW-1:0] SMIN = {{(OW - W + 1){1'b1}}, {(W - 1){1'b0}}};
   localparam logic [OW-1:0] UMAX = {{(OW - W){1'b0}}, {W{1'b1}}};

   // Clamp to the W-bit range of the frame mode; unsigned sums are never negative.
   always_comb begin
      w_out_sum = r_acc;
      w_out_sat = 1'b0;
      if (r_acc_mode) begin
         if ($signed(r_acc) > $signed(SMAX)) begin
            w_out_sum = SMAX;
            w_out_sat = 1'b1;
         end else if ($signed(r_acc) < $signed(SMIN)) begin
            w_out_sum = SMIN;
            w_out_sat = 1'b1;
         end
      end else if (r_acc > UMAX) begin
         w_out_sum = UMAX;
         w_out_sat = 1'b1;
      end
   end
`else
   assign w_out_sum = r_acc;
   assign w_out_sat = 1'b0;
`endif

   // Output register: loaded from DONE, released by the consumer.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         out_valid  <= 1'b0;
         sum_out    <= '0;
         sum_signed <= 1'b0;
         sat        <= 1'b0;
      end else if (clear) begin
         out_valid  <= 1'b0;
      end else if (w_load) begin
         out_valid  <= 1'b1;
         sum_out    <= w_out_sum;
         sum_signed <= r_acc_mode;
         sat        <= w_out_sat;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sym_add_acc.sv
// tb_sym_add_acc: directed and randomized bench for sym_add_acc (W=4, ACC_LEN=4).
// Expected frame sums come from an integer model that groups accepted pairs into
// frames; SYM_ADD_SAT_EN selects the clamped expectations.
module tb_sym_add_acc;

   localparam int unsigned W       = 4;
   localparam int unsigned ACC_LEN = 4;
   localparam int unsigned OW      = W + 1 + 2;

`ifdef SYM_ADD_SAT_EN
   localparam int E120 = 15;   localparam int E120_SAT = 1;
   localparam int EM64 = 'h78; localparam int EM64_SAT = 1;
`else
   localparam int E120 = 120;  localparam int E120_SAT = 0;
   localparam int EM64 = 'h40; localparam int EM64_SAT = 0;
`endif

   logic          sys_clk = 1'b0;
   logic          sys_rst_n;
   logic          clear;
   logic          signed_mode;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  d1;
   logic [W-1:0]  d2;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] sum_out;
   logic          sum_signed;
   logic          sat;

   always #5 sys_clk = ~sys_clk;

   sym_add_acc #(
      .W       (W),
      .ACC_LEN (ACC_LEN)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .clear       (clear),
      .signed_mode (signed_mode),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .d1          (d1),
      .d2          (d2),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .sum_out     (sum_out),
      .sum_signed  (sum_signed),
      .sat         (sat)
   );

   typedef struct {
      int sum;
      bit sgn;
      bit sat;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   m_cnt, m_sum;
   bit   m_mode;
   int   step_idx, last_xfer;
   bit   prev_ov, lat_chk, last_fire, ordy;
   int   last_sum;
   bit   last_sgn, last_sat;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int ival(input logic [W-1:0] d, input bit s);
      return s ? int'($signed(d)) : int'(d);
   endfunction

   // Close a frame in the model: clamp if enabled, truncate to OW bits.
   function automatic exp_t make_exp(input int s, input bit sgn);
      exp_t e;
      e.sat = 0;
`ifdef SYM_ADD_SAT_EN
      if (sgn) begin
         if (s > 7)  begin s = 7;  e.sat = 1; end
         if (s < -8) begin s = -8; e.sat = 1; end
      end else if (s > 15) begin
         s = 15; e.sat = 1;
      end
`endif
      e.sum = s & ((1 << OW) - 1);
      e.sgn = sgn;
      return e;
   endfunction

   // One clock: drive at negedge, sample outputs, update model with accepted pair.
   task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic m, input logic clr);
      exp_t e;
      @(negedge sys_clk);
      in_valid = v; d1 = a; d2 = b; signed_mode = m; clear = clr; out_ready = ordy;
      #1;
      step_idx++;
      if (out_valid && !prev_ov && lat_chk)
         chk("latency", 32'(step_idx - last_xfer - 1), 32'd2);
      prev_ov = out_valid;
      if (out_valid === 1'b1) begin
         chk("out_pending", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            chk("sum_out", 32'(sum_out), 32'(q[0].sum));
            chk("sum_signed", 32'(sum_signed), 32'(q[0].sgn));
            chk("sat", 32'(sat), 32'(q[0].sat));
            if (out_ready) begin
               last_sum = int'(sum_out); last_sgn = sum_signed; last_sat = sat;
               void'(q.pop_front());
            end
         end
      end
      last_fire = v && in_ready && !clr;
      if (clr) begin
         m_cnt = 0; m_sum = 0;
      end else if (last_fire) begin
         if (m_cnt == 0) m_mode = m;
         m_sum += ival(a, m_mode) + ival(b, m_mode);
         m_cnt++;
         if (m_cnt == ACC_LEN) begin
            e = make_exp(m_sum, m_mode);
            q.push_back(e);
            m_cnt = 0; m_sum = 0;
            last_xfer = step_idx;
         end
      end
   endtask

   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
      int tries;
      tries = 0;
      do begin
         step(1'b1, a, b, m, 1'b0);
         tries++;
      end while (!last_fire && tries < 40);
      chk("push_accepted", 32'(last_fire), 32'd1);
   endtask

   task automatic drain();
      int t;
      ordy = 1; t = 0;
      while (q.size() != 0 && t < 30) begin
         step(1'b0, '0, '0, 1'b0, 1'b0);
         t++;
      end
      chk("drain_empty", 32'(q.size()), 32'd0);
      step(1'b0, '0, '0, 1'b0, 1'b0);
      chk("drain_out_valid", 32'(out_valid), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge sys_clk);
      sys_rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum_out", 32'(sum_out), 32'd0);
      chk("rst_sum_signed", 32'(sum_signed), 32'd0);
      chk("rst_sat", 32'(sat), 32'd0);
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      m_cnt = 0; m_sum = 0; q.delete(); prev_ov = 0;
   endtask

   initial begin
      sys_rst_n = 1'b0; clear = 1'b0; signed_mode = 1'b0; in_valid = 1'b0;
      d1 = '0; d2 = '0; out_ready = 1'b1; ordy = 1;
      m_cnt = 0; m_sum = 0; m_mode = 0; step_idx = 0; last_xfer = 0;
      prev_ov = 0; lat_chk = 1; last_fire = 0;
      do_reset();

      // Unsigned 15+15 x4 -> 120
      ordy = 1;
      repeat (4) push(4'd15, 4'd15, 1'b0);
      drain();
      chk("u120_sum", 32'(last_sum), 32'(E120));
      chk("u120_sgn", 32'(last_sgn), 32'd0);
      chk("u120_sat", 32'(last_sat), 32'(E120_SAT));

      // Signed -8+-8 x4 -> -64
      repeat (4) push(4'h8, 4'h8, 1'b1);
      drain();
      chk("s64_sum", 32'(last_sum), 32'(EM64));
      chk("s64_sgn", 32'(last_sgn), 32'd1);
      chk("s64_sat", 32'(last_sat), 32'(EM64_SAT));

      // Consumer stall at DONE, next frame waits then flows
      ordy = 0;
      repeat (4) push(4'd15, 4'd15, 1'b0);
      for (int i = 0; i < 10 && !prev_ov; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
      chk("stall_out_valid", 32'(prev_ov), 32'd1);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 4'd1, 4'd1, 1'b0, 1'b0);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
      ordy = 1;
      repeat (4) push(4'd1, 4'd1, 1'b0);
      drain();
      chk("stall_2nd_sum", 32'(last_sum), 32'd8);

      // Mode toggled after the first pair is ignored for the frame
      push(4'd15, 4'd15, 1'b0);
      repeat (3) push(4'd15, 4'd15, 1'b1);
      drain();
      chk("mode_latch_sum", 32'(last_sum), 32'(E120));
      chk("mode_latch_sgn", 32'(last_sgn), 32'd0);

      // Clear with a pair on the input: partial frame and that pair dropped
      repeat (2) push(4'd1, 4'd2, 1'b0);
      step(1'b1, 4'd1, 4'd2, 1'b0, 1'b1);
      repeat (4) push(4'd1, 4'd2, 1'b0);
      drain();
      chk("clear_sum", 32'(last_sum), 32'd12);

      // Reset mid-frame
      repeat (2) push(4'd1, 4'd1, 1'b0);
      do_reset();
      repeat (4) push(4'd1, 4'd1, 1'b0);
      drain();
      chk("reset_sum", 32'(last_sum), 32'd8);

      // Back-to-back frames at full rate
      lat_chk = 0;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)), 1'b0);
         chk("b2b_accept", 32'(last_fire), 32'd1);
      end
      drain();

      // Randomized traffic with random backpressure and mid-frame mode changes
      for (int i = 0; i < 300; i++) begin
         ordy = ($urandom_range(3) != 0);
         step(1'($urandom_range(1)), 4'($urandom_range(15)), 4'($urandom_range(15)),
              1'($urandom_range(1)), 1'b0);
      end
      // Complete any partial frame so the queue can drain
      ordy = 1;
      while (m_cnt != 0) push(4'($urandom_range(15)), 4'($urandom_range(15)), 1'b0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
